// File: rtl/gat_pkg.sv
// Shared sizing and state definitions for the GAT new-feature buffer readers.
package gat_pkg;

  localparam int NEW_FEATURE_WIDTH  = 32;
  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NUM_SUBGRAPHS      = 2708;
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);
  localparam int LABEL_W            = $clog2(NUM_FEATURE_OUT);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } reader_state_t;

endpackage

// File: rtl/feature_reader_if.sv
// Valid/ready feature stream leaving the reader, one node per packet.
interface feature_reader_if #(
  parameter int WIDTH = gat_pkg::NEW_FEATURE_WIDTH
);

  logic [WIDTH-1:0] feat_out_data;
  logic             feat_out_vld;
  logic             feat_out_rdy;
  logic             feat_out_last;

  modport master (
    output feat_out_data,
    output feat_out_vld,
    output feat_out_last,
    input  feat_out_rdy
  );

  modport slave (
    input  feat_out_data,
    input  feat_out_vld,
    input  feat_out_last,
    output feat_out_rdy
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; the head entry is always visible on pop_data.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (occ == OCC_W'(DEPTH));
  assign empty    = (occ == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/feature_reader.sv
// Drains the new-feature BRAM after gat_ready rises, streaming every word with a
// per-node last marker and an on-the-fly argmax class label.
module feature_reader #(
  parameter  int NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
  parameter  int NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
  parameter  int NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
  parameter  int BRAM_RD_LATENCY    = 2,
  parameter  int FIFO_DEPTH         = 4,
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  localparam int LABEL_W            = $clog2(NUM_FEATURE_OUT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
  output logic                          feat_bram_enb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_doutb,
  feature_reader_if.master              feat_out,
  output logic [LABEL_W-1:0]            label_o,
  output logic                          label_vld,
  output logic                          busy_o,
  output logic                          done_o
);

  import gat_pkg::*;

  localparam int LAT    = BRAM_RD_LATENCY;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int NODE_W = (NUM_SUBGRAPHS > 1) ? $clog2(NUM_SUBGRAPHS) : 1;

  reader_state_t                   state;
  logic                            gat_ready_q;
  logic [NEW_FEATURE_ADDR_W-1:0]   rd_addr;
  logic [LABEL_W-1:0]              issue_beat;
  logic [LABEL_W-1:0]              out_beat;
  logic [NODE_W-1:0]               node_cnt;
  logic [LAT-1:0]                  vld_sr;
  logic [LAT-1:0]                  last_sr;
  logic [OCC_W-1:0]                inflight;
  logic [OCC_W-1:0]                occ;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [NEW_FEATURE_WIDTH:0]      fifo_head;
  logic [NEW_FEATURE_WIDTH-1:0]    max_val;
  logic [LABEL_W-1:0]              max_idx;
  logic                            issue;
  logic                            issue_last;
  logic                            push;
  logic                            pop;
  logic                            beat_wins;
  logic                            final_pop;

  // Credit covers both buffered and in-flight words so a returning read always has a slot.
  assign issue = (state == READ) &&
                 ((OCC_W+1)'(occ) + (OCC_W+1)'(inflight) < (OCC_W+1)'(FIFO_DEPTH));
  assign issue_last      = (issue_beat == LABEL_W'(NUM_FEATURE_OUT - 1));
  assign feat_bram_enb   = issue;
  assign feat_bram_addrb = rd_addr;

  assign push = vld_sr[LAT-1];
  assign pop  = feat_out.feat_out_vld && feat_out.feat_out_rdy;

  assign feat_out.feat_out_vld  = !fifo_empty;
  assign feat_out.feat_out_data = fifo_empty ? '0 : fifo_head[NEW_FEATURE_WIDTH-1:0];
  assign feat_out.feat_out_last = !fifo_empty && fifo_head[NEW_FEATURE_WIDTH];

  assign beat_wins = (feat_out.feat_out_data > max_val);
  assign final_pop = pop && feat_out.feat_out_last &&
                     (node_cnt == NODE_W'(NUM_SUBGRAPHS - 1));

  sync_fifo #(
    .WIDTH (NEW_FEATURE_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({last_sr[LAT-1], feat_bram_doutb}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .occ       (occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gat_ready_q <= 1'b0;
      rd_addr     <= '0;
      issue_beat  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      gat_ready_q <= gat_ready;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (gat_ready && !gat_ready_q) begin
            state      <= READ;
            rd_addr    <= '0;
            issue_beat <= '0;
            busy_o     <= 1'b1;
          end
        end
        READ: begin
          if (issue) begin
            rd_addr    <= rd_addr + 1'b1;
            issue_beat <= issue_last ? '0 : issue_beat + 1'b1;
            if (rd_addr == NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (final_pop && (inflight == '0) && (occ == OCC_W'(1))) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags each BRAM slot as it comes back; a reset clears the tags so stale reads are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      last_sr  <= '0;
      inflight <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= issue && issue_last;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      inflight <= inflight + OCC_W'(issue) - OCC_W'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_beat  <= '0;
      node_cnt  <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      label_o   <= '0;
      label_vld <= 1'b0;
    end else begin
      label_vld <= 1'b0;
      if (pop) begin
        if (feat_out.feat_out_last) begin
          out_beat  <= '0;
          node_cnt  <= (node_cnt == NODE_W'(NUM_SUBGRAPHS - 1)) ? '0 : node_cnt + 1'b1;
          label_o   <= (out_beat == '0) ? '0 : (beat_wins ? out_beat : max_idx);
          label_vld <= 1'b1;
        end else begin
          out_beat <= out_beat + 1'b1;
        end
        // Strict compare keeps the lowest index on ties.
        if (out_beat == '0) begin
          max_val <= feat_out.feat_out_data;
          max_idx <= '0;
        end else if (beat_wins) begin
          max_val <= feat_out.feat_out_data;
          max_idx <= out_beat;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_feature_reader.sv
// Randomised scoreboard bench for feature_reader with a latency-modelled BRAM.
module tb_feature_reader;

  localparam int W     = 32;
  localparam int NF    = 4;
  localparam int NS    = 2;
  localparam int LAT   = 2;
  localparam int FD    = 4;
  localparam int DEPTH = NS * NF;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(NF);

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          gat_ready;
  logic [AW-1:0] addrb;
  logic          enb;
  logic [W-1:0]  doutb;
  logic [LW-1:0] label_o;
  logic          label_vld;
  logic          busy_o;
  logic          done_o;

  feature_reader_if #(.WIDTH(W)) stream_if ();

  feature_reader #(
    .NEW_FEATURE_WIDTH (W),
    .NUM_FEATURE_OUT   (NF),
    .NUM_SUBGRAPHS     (NS),
    .BRAM_RD_LATENCY   (LAT),
    .FIFO_DEPTH        (FD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gat_ready       (gat_ready),
    .feat_bram_addrb (addrb),
    .feat_bram_enb   (enb),
    .feat_bram_doutb (doutb),
    .feat_out        (stream_if),
    .label_o         (label_o),
    .label_vld       (label_vld),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  logic [W-1:0] mem  [DEPTH];
  logic [W-1:0] pipe [LAT];
  int           tie_pat [DEPTH] = '{5, 9, 9, 2, 0, 0, 0, 0};

  beat_t exp_q[$];
  int    lab_q[$];
  beat_t e_in;
  beat_t e_out;
  int    lab_exp;
  int    errors = 0;
  int    checks = 0;
  int    done_pending = 0;
  int    done_seen = 0;
  int    done_cyc = 0;
  int    accepted = 0;
  int    issue_idx = 0;
  int    outstanding = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // BRAM read port: data appears LAT cycles after the enable cycle.
  always @(posedge clk) begin
    if (enb) pipe[0] <= mem[addrb];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign doutb = pipe[LAT-1];

  initial begin
    stream_if.feat_out_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       stream_if.feat_out_rdy = 1'b1;
        1:       stream_if.feat_out_rdy = 1'($urandom_range(0, 1));
        default: stream_if.feat_out_rdy = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int refArgmax(input int node);
    int best = 0;
    for (int b = 1; b < NF; b++)
      if (mem[node*NF + b] > mem[node*NF + best]) best = b;
    return best;
  endfunction

  task automatic applyStimulus(input int pattern);
    gat_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      case (pattern)
        0:       mem[a] = W'(a + 1);
        1:       mem[a] = W'($urandom_range(0, 7));
        default: mem[a] = W'(tie_pat[a]);
      endcase
    end
    for (int n = 0; n < NS; n++) begin
      for (int b = 0; b < NF; b++) begin
        e_in.data = mem[n*NF + b];
        e_in.last = (b == NF - 1);
        exp_q.push_back(e_in);
      end
      lab_q.push_back(refArgmax(n));
    end
    done_pending++;
    issue_idx = 0;
    gat_ready = 1'b1;
  endtask

  task automatic waitDone(input int budget);
    int start = done_seen;
    int n = 0;
    while (done_seen == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_seen == start) checkOutput("done_timeout", 0, 1);
  endtask

  // Monitor: pops expectations whenever the DUT hands over a beat, label or done.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall) begin
        checkOutput("vld_held", stream_if.feat_out_vld, 1);
        checkOutput("data_held", stream_if.feat_out_data, prev_data);
        checkOutput("last_held", stream_if.feat_out_last, prev_last);
      end
      prev_stall = stream_if.feat_out_vld && !stream_if.feat_out_rdy;
      prev_data  = stream_if.feat_out_data;
      prev_last  = stream_if.feat_out_last;
      if (stream_if.feat_out_vld && stream_if.feat_out_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %0d expected no beat", stream_if.feat_out_data);
        end else begin
          e_out = exp_q.pop_front();
          checkOutput("beat_data", stream_if.feat_out_data, e_out.data);
          checkOutput("beat_last", stream_if.feat_out_last, e_out.last);
        end
        accepted++;
      end
      if (enb) begin
        checkOutput("issue_addr", addrb, issue_idx);
        checkOutput("credit_ok", outstanding < FD, 1);
        issue_idx++;
      end
      outstanding += (enb ? 1 : 0) - ((stream_if.feat_out_vld && stream_if.feat_out_rdy) ? 1 : 0);
      if (label_vld) begin
        if (lab_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_label: got %0d expected no label", label_o);
        end else begin
          lab_exp = lab_q.pop_front();
          checkOutput("label", label_o, lab_exp);
        end
      end
      if (done_o) begin
        checkOutput("done_expected", done_pending > 0, 1);
        if (done_pending > 0) done_pending--;
        checkOutput("busy_after_done", busy_o, 0);
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int v0;
    int base;
    rst_n     = 1'b0;
    gat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_vld", stream_if.feat_out_vld, 0);
    checkOutput("rst_enb", enb, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_label_vld", label_vld, 0);
    checkOutput("rst_label", label_o, 0);

    $display("[TB] full throughput");
    rdy_mode = 0;
    applyStimulus(0);
    n = 0;
    do begin @(negedge clk); n++; end while (!enb && n < 20);
    checkOutput("issue_latency", n, 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!stream_if.feat_out_vld && n < 20);
    checkOutput("vld_latency", n, 3);
    v0 = cyc;
    waitDone(300);
    checkOutput("burst_cycles", done_cyc - v0, 8);
    @(posedge clk); #1;
    checkOutput("busy_idle", busy_o, 0);

    $display("[TB] random backpressure");
    for (int r = 0; r < 4; r++) begin
      rdy_mode = 1;
      applyStimulus(r == 0 ? 0 : 1);
      waitDone(600);
    end

    $display("[TB] argmax ties");
    rdy_mode = 0;
    applyStimulus(2);
    waitDone(300);

    $display("[TB] edge detect");
    applyStimulus(0);
    repeat (4) @(posedge clk);
    #1 gat_ready = 1'b0;
    @(posedge clk);
    #1 gat_ready = 1'b1;
    waitDone(300);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_restart_busy", busy_o, 0);
    applyStimulus(0);
    waitDone(300);

    $display("[TB] reset mid readout");
    applyStimulus(0);
    base = accepted;
    @(posedge clk);
    #1 gat_ready = 1'b0;
    n = 0;
    while (accepted < base + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("beats_before_reset", accepted - base, 3);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    lab_q.delete();
    done_pending = 0;
    rst_n = 1'b1;
    checkOutput("mid_rst_vld", stream_if.feat_out_vld, 0);
    checkOutput("mid_rst_data", stream_if.feat_out_data, 0);
    checkOutput("mid_rst_last", stream_if.feat_out_last, 0);
    checkOutput("mid_rst_enb", enb, 0);
    checkOutput("mid_rst_addr", addrb, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_label", label_o, 0);
    repeat (10) @(posedge clk);
    applyStimulus(0);
    waitDone(300);

    $display("[TB] ready held low");
    rdy_mode = 2;
    applyStimulus(0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("stalled_issues", issue_idx, FD);
    checkOutput("stalled_vld", stream_if.feat_out_vld, 1);
    checkOutput("stalled_data", stream_if.feat_out_data, 1);
    rdy_mode = 0;
    waitDone(300);

    repeat (10) @(posedge clk);
    checkOutput("beats_drained", exp_q.size(), 0);
    checkOutput("labels_drained", lab_q.size(), 0);
    checkOutput("dones_drained", done_pending, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
